conv_tile_scheduler: RTL and testbench

Sequences the matrix_convolution engine across a full feature map held in an external 8-bit buffer. For each tile it loads a 6x6 input window into the engine's tile register, pulses start, and waits for done. It then captures the 4x4 result and writes it to an external 16-bit output buffer. Tiles advance with stride 4, so a single start command produces the complete valid-mode 3x3 convolution of the map. The kernel is driven to the engine directly by upstream logic and is not handled here.

---
 rtl/conv_tile_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_conv_tile_scheduler.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_tile_scheduler.sv
// conv_tile_scheduler: walks a feature map tile by tile through a 3x3 convolution engine.
// Each tile: 36 byte reads into input_tile, start pulse, wait for conv_done, settle,
// latch the 4x4 result, 16 word writes, engine reset, advance (stride 4).
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   start / busy / done / error      pass control and status (error is sticky)
//   fmap_rd_en, fmap_addr, fmap_rdata   input buffer read port (1-cycle latency)
//   input_tile                       6x6 signed window presented to the engine
//   conv_start, conv_rst_n, conv_done, conv_c   engine handshake and 4x4 result
//   out_wr_en, out_addr, out_wdata   output buffer write port
//   tile_row, tile_col               current tile indices
module conv_tile_scheduler #(
    parameter int unsigned IMG_W        = 18,
    parameter int unsigned IMG_H        = 18,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned START_HOLD   = 4,
    parameter int unsigned SETTLE       = 10,
    parameter int unsigned CONV_RST_CYC = 4,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic                             fmap_rd_en,
    output logic [ADDR_W-1:0]                fmap_addr,
    input  logic signed [7:0]                fmap_rdata,
    output logic signed [0:5][0:5][7:0]      input_tile,
    output logic                             conv_start,
    output logic                             conv_rst_n,
    input  logic                             conv_done,
    input  logic signed [0:3][0:3][15:0]     conv_c,
    output logic                             out_wr_en,
    output logic [ADDR_W-1:0]                out_addr,
    output logic signed [15:0]               out_wdata,
    output logic [7:0]                       tile_row,
    output logic [7:0]                       tile_col
);

    localparam int unsigned OUT_W     = IMG_W - 2;
    localparam int unsigned TILES_X   = OUT_W / 4;
    localparam int unsigned TILES_Y   = (IMG_H - 2) / 4;
    localparam int unsigned LOAD_RD   = 36;
    localparam int unsigned LOAD_CYC  = LOAD_RD + 1;
    localparam int unsigned STORE_CYC = 16;
    localparam int unsigned CNT_W     = $clog2(TIMEOUT + LOAD_CYC + START_HOLD + SETTLE
                                               + CONV_RST_CYC + STORE_CYC);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT, S_SETTLE, S_STORE, S_NEXT, S_FINISH
    } state_t;

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [2:0]                      i_q, i_d, j_q, j_d;
    logic [7:0]                      row_d, col_d;
    logic                            err_d, done_d;
    logic signed [0:3][0:3][15:0]    res_q, res_d;
    logic                            rd_vld_q;
    logic [2:0]                      cap_i_q, cap_j_q;
    logic                            rd_en_d, wr_en_d;
    logic [ADDR_W-1:0]               rd_addr_d, wr_addr_d;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state, per-state cycle counter, tile walk and window position
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        i_d     = i_q;
        j_d     = j_q;
        row_d   = tile_row;
        col_d   = tile_col;
        err_d   = error;
        done_d  = 1'b0;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_LOAD;
                    err_d   = 1'b0;
                    row_d   = '0;
                    col_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            S_LOAD: begin
                if (j_q == 3'd5) begin
                    j_d = '0;
                    i_d = i_q + 3'd1;
                end else begin
                    j_d = j_q + 3'd1;
                end
                if (cnt_q == CNT_W'(LOAD_CYC - 1)) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_W'(START_HOLD - 1)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (conv_done) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    state_d = S_STORE;
                    cnt_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    res_d   = conv_c;
                end
            end
            S_STORE: begin
                if (j_q == 3'd3) begin
                    j_d = '0;
                    i_d = i_q + 3'd1;
                end else begin
                    j_d = j_q + 3'd1;
                end
                if (cnt_q == CNT_W'(STORE_CYC - 1)) begin
                    state_d = S_NEXT;
                    cnt_d   = '0;
                end
            end
            S_NEXT: begin
                if (cnt_q == CNT_W'(CONV_RST_CYC - 1)) begin
                    cnt_d = '0;
                    i_d   = '0;
                    j_d   = '0;
                    if (tile_row == 8'(TILES_Y - 1) && tile_col == 8'(TILES_X - 1)) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                        if (tile_col == 8'(TILES_X - 1)) begin
                            col_d = '0;
                            row_d = tile_row + 8'd1;
                        end else begin
                            col_d = tile_col + 8'd1;
                        end
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Buffer strobes and addresses for the coming cycle
    assign rd_en_d   = (state_d == S_LOAD) && (cnt_d < CNT_W'(LOAD_RD));
    assign wr_en_d   = (state_d == S_STORE);
    assign rd_addr_d = ADDR_W'((32'(row_d) * 32'd4 + 32'(i_d)) * IMG_W
                               + 32'(col_d) * 32'd4 + 32'(j_d));
    assign wr_addr_d = ADDR_W'((32'(row_d) * 32'd4 + 32'(i_d)) * OUT_W
                               + 32'(col_d) * 32'd4 + 32'(j_d));

    // Registered outputs and datapath; read data lands one cycle after its strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            i_q        <= '0;
            j_q        <= '0;
            tile_row   <= '0;
            tile_col   <= '0;
            error      <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            res_q      <= '0;
            conv_start <= 1'b0;
            conv_rst_n <= 1'b0;
            fmap_rd_en <= 1'b0;
            fmap_addr  <= '0;
            out_wr_en  <= 1'b0;
            out_addr   <= '0;
            out_wdata  <= '0;
            rd_vld_q   <= 1'b0;
            cap_i_q    <= '0;
            cap_j_q    <= '0;
            input_tile <= '0;
        end else begin
            cnt_q      <= cnt_d;
            i_q        <= i_d;
            j_q        <= j_d;
            tile_row   <= row_d;
            tile_col   <= col_d;
            error      <= err_d;
            done       <= done_d;
            busy       <= (state_d != S_IDLE);
            res_q      <= res_d;
            conv_start <= (state_d == S_START);
            conv_rst_n <= (state_d != S_NEXT);
            fmap_rd_en <= rd_en_d;
            fmap_addr  <= rd_en_d ? rd_addr_d : '0;
            out_wr_en  <= wr_en_d;
            out_addr   <= wr_en_d ? wr_addr_d : '0;
            out_wdata  <= wr_en_d ? res_d[i_d[1:0]][j_d[1:0]] : '0;
            rd_vld_q   <= fmap_rd_en;
            cap_i_q    <= i_q;
            cap_j_q    <= j_q;
            if (rd_vld_q) input_tile[cap_i_q][cap_j_q] <= fmap_rdata;
        end
    end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Self-checking bench for conv_tile_scheduler: behavioural engine, ramp feature map,
// output buffer scoreboard against a golden valid 3x3 correlation of the whole map.
module tb_conv_tile_scheduler;

    localparam int unsigned IMG_W       = 18;
    localparam int unsigned ADDR_W      = 10;
    localparam int          ENG_DLY     = 10;    // gives 8 WAIT cycles per tile
    localparam int          TILE_PERIOD = 79;    // 37+4+8+10+16+4
    localparam int          PASS_CYC    = 1264;  // 16 tiles, FINISH right after last NEXT
    localparam int          ABORT_CYC   = 1065;  // 37 LOAD + 4 START + 1024 WAIT

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         rst_n, start;
    logic                         busy, done, error;
    logic                         fmap_rd_en;
    logic [ADDR_W-1:0]            fmap_addr;
    logic signed [7:0]            fmap_rdata;
    logic signed [0:5][0:5][7:0]  input_tile;
    logic                         conv_start, conv_rst_n;
    logic                         conv_done_w;
    logic signed [0:3][0:3][15:0] conv_c_r;
    logic                         out_wr_en;
    logic [ADDR_W-1:0]            out_addr;
    logic signed [15:0]           out_wdata;
    logic [7:0]                   tile_row, tile_col;

    conv_tile_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .fmap_rd_en (fmap_rd_en),
        .fmap_addr  (fmap_addr),
        .fmap_rdata (fmap_rdata),
        .input_tile (input_tile),
        .conv_start (conv_start),
        .conv_rst_n (conv_rst_n),
        .conv_done  (conv_done_w),
        .conv_c     (conv_c_r),
        .out_wr_en  (out_wr_en),
        .out_addr   (out_addr),
        .out_wdata  (out_wdata),
        .tile_row   (tile_row),
        .tile_col   (tile_col)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  fmap_mem [0:1023];
    int          kern [0:2][0:2];
    logic        spur_done, eng_off, clr;

    // Input buffer: synchronous read
    always @(posedge clk) if (fmap_rd_en) fmap_rdata <= fmap_mem[fmap_addr];

    // Engine model: fixed latency from the rising edge of conv_start
    logic       start_prev = 1'b0;
    logic       eng_done   = 1'b0;
    int         eng_cnt    = 0;
    assign conv_done_w = eng_done | spur_done;

    function automatic logic [15:0] eng_sum(int i, int j);
        int s = 0;
        for (int u = 0; u < 3; u++)
            for (int v = 0; v < 3; v++)
                s += int'($signed(input_tile[i+u][j+v])) * kern[u][v];
        return 16'(s);
    endfunction

    always @(posedge clk) begin
        start_prev <= conv_start;
        if (conv_start && !start_prev && !eng_off) eng_cnt <= ENG_DLY;
        else if (eng_cnt != 0)                      eng_cnt <= eng_cnt - 1;
        eng_done <= (eng_cnt == 1);
        if (eng_cnt == 1)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    conv_c_r[i][j] <= eng_sum(i, j);
    end

    // Monitor: read/write bookkeeping and output buffer
    int                 cyc = 0;
    int                 done_cnt, wr_cnt;
    bit                 overlap;
    int                 rd_cnt [0:15];
    int                 first_rd_cyc [0:15];
    logic [ADDR_W-1:0]  first_rd [0:15];
    logic [ADDR_W-1:0]  last_rd [0:15];
    logic [ADDR_W-1:0]  first_wr [0:15];
    logic [15:0]        outbuf [0:255];

    always @(posedge clk) begin : mon
        int t;
        cyc <= cyc + 1;
        t = int'(tile_row) * 4 + int'(tile_col);
        if (clr) begin
            done_cnt <= 0;
            wr_cnt   <= 0;
            overlap  <= 1'b0;
            for (int k = 0; k < 16; k++) rd_cnt[k] <= 0;
            for (int a = 0; a < 256; a++) outbuf[a] <= 'x;
        end else begin
            if (done) done_cnt <= done_cnt + 1;
            if (fmap_rd_en && out_wr_en) overlap <= 1'b1;
            if (fmap_rd_en && t < 16) begin
                if (rd_cnt[t] == 0) begin
                    first_rd[t]     <= fmap_addr;
                    first_rd_cyc[t] <= cyc;
                end
                if (rd_cnt[t] == 35) last_rd[t] <= fmap_addr;
                rd_cnt[t] <= rd_cnt[t] + 1;
            end
            if (out_wr_en) begin
                if (wr_cnt % 16 == 0 && t < 16) first_wr[t] <= out_addr;
                if (out_addr < 256) outbuf[out_addr] <= out_wdata;
                wr_cnt <= wr_cnt + 1;
            end
        end
    end

    function automatic int gold(int r, int c);
        int s = 0;
        logic [7:0] b;
        for (int u = 0; u < 3; u++)
            for (int v = 0; v < 3; v++) begin
                b = 8'((r + u) * IMG_W + c + v);
                s += int'($signed(b)) * kern[u][v];
            end
        return s;
    endfunction

    function automatic int count_out_errors();
        int n = 0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                if (outbuf[r*16+c] !== 16'(gold(r, c))) n++;
        return n;
    endfunction

    task automatic do_clear();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge of LOAD cycle 0
    task automatic start_pass();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n, output bit ok);
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (done === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, error, fmap_rd_en, conv_start, conv_rst_n, out_wr_en} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {busy, done, error, fmap_rd_en, conv_start, conv_rst_n, out_wr_en});
        end
        total++;
        if ({fmap_addr, out_addr, out_wdata, tile_row, tile_col} !== '0) begin
            bad++;
            $display("FAIL reset_data: addr=%0d oaddr=%0d wdata=%0d row=%0d col=%0d want all 0",
                     fmap_addr, out_addr, out_wdata, tile_row, tile_col);
        end
        total++;
        if (input_tile !== '0) begin
            bad++;
            $display("FAIL reset_tile: got %h want 0", input_tile);
        end
        do_clear();
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (conv_rst_n !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: conv_rst_n=%b busy=%b want 1 0", conv_rst_n, busy);
        end
    endtask

    task automatic test_full_pass();
        int n;
        bit ok;
        int e;
        do_clear();
        start_pass();
        total++;
        if (busy !== 1'b1 || fmap_rd_en !== 1'b1 || fmap_addr !== 10'd0) begin
            bad++;
            $display("FAIL first_read: busy=%b rd_en=%b addr=%0d want 1 1 0",
                     busy, fmap_rd_en, fmap_addr);
        end
        // Spurious conv_done during LOAD must not disturb the load
        repeat (2) @(negedge clk);
        spur_done = 1'b1;
        repeat (2) @(negedge clk);
        spur_done = 1'b0;
        total++;
        if (fmap_rd_en !== 1'b1 || conv_start !== 1'b0 || fmap_addr !== 10'd4) begin
            bad++;
            $display("FAIL spurious_done: rd_en=%b conv_start=%b addr=%0d want 1 0 4",
                     fmap_rd_en, conv_start, fmap_addr);
        end
        wait_done(3000, n, ok);
        total++;
        if (!ok || n + 4 != PASS_CYC) begin
            bad++;
            $display("FAIL pass_latency: done=%b cycles=%0d want 1 %0d", ok, n + 4, PASS_CYC);
        end
        @(negedge clk);
        total++;
        if (done_cnt != 1 || busy !== 1'b0 || error !== 1'b0) begin
            bad++;
            $display("FAIL pass_end: done_pulses=%0d busy=%b error=%b want 1 0 0",
                     done_cnt, busy, error);
        end
        e = count_out_errors();
        total++;
        if (e != 0 || wr_cnt != 256) begin
            bad++;
            $display("FAIL pass_data: wrong_words=%0d writes=%0d want 0 256", e, wr_cnt);
        end
        for (int t = 0; t < 16; t++) begin
            total++;
            if (rd_cnt[t] != 36) begin
                bad++;
                $display("FAIL tile_reads[%0d]: got %0d want 36", t, rd_cnt[t]);
            end
        end
        total++;
        if (first_rd[6] !== 10'd80 || last_rd[6] !== 10'd175 || first_wr[6] !== 10'd72) begin
            bad++;
            $display("FAIL tile6_addr: rd %0d..%0d wr %0d want 80..175 wr 72",
                     first_rd[6], last_rd[6], first_wr[6]);
        end
        total++;
        if (first_rd_cyc[1] - first_rd_cyc[0] != TILE_PERIOD) begin
            bad++;
            $display("FAIL tile_period: got %0d want %0d",
                     first_rd_cyc[1] - first_rd_cyc[0], TILE_PERIOD);
        end
        total++;
        if (overlap) begin
            bad++;
            $display("FAIL rd_wr_overlap: got 1 want 0");
        end
    endtask

    task automatic test_start_in_wait();
        int n;
        bit ok;
        int e;
        do_clear();
        start_pass();
        n = 0;
        while (conv_start !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        while (conv_start !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (n >= 200 || busy !== 1'b1 || fmap_rd_en !== 1'b0 || tile_row !== 8'd0
            || tile_col !== 8'd0) begin
            bad++;
            $display("FAIL start_in_wait: n=%0d busy=%b rd_en=%b row=%0d col=%0d want busy 1 rd 0 tile 0,0",
                     n, busy, fmap_rd_en, tile_row, tile_col);
        end
        wait_done(3000, n, ok);
        @(negedge clk);
        e = count_out_errors();
        total++;
        if (!ok || done_cnt != 1 || e != 0 || rd_cnt[0] != 36) begin
            bad++;
            $display("FAIL wait_restart_pass: done=%b pulses=%0d wrong_words=%0d tile0_reads=%0d want 1 1 0 36",
                     ok, done_cnt, e, rd_cnt[0]);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit ok;
        int e;
        eng_off = 1'b1;
        do_clear();
        start_pass();
        wait_done(1200, n, ok);
        total++;
        if (!ok || n != ABORT_CYC) begin
            bad++;
            $display("FAIL timeout_latency: done=%b cycles=%0d want 1 %0d", ok, n, ABORT_CYC);
        end
        total++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_flags: error=%b busy=%b want 1 0", error, busy);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || done_cnt != 1 || wr_cnt != 0 || error !== 1'b1) begin
            bad++;
            $display("FAIL timeout_after: done=%b pulses=%0d writes=%0d error=%b want 0 1 0 1",
                     done, done_cnt, wr_cnt, error);
        end
        eng_off = 1'b0;
        do_clear();
        start_pass();
        total++;
        if (error !== 1'b0) begin
            bad++;
            $display("FAIL error_clear: got %b want 0", error);
        end
        wait_done(3000, n, ok);
        e = count_out_errors();
        total++;
        if (!ok || e != 0 || error !== 1'b0) begin
            bad++;
            $display("FAIL pass_after_timeout: done=%b wrong_words=%0d error=%b want 1 0 0",
                     ok, e, error);
        end
    endtask

    task automatic test_reset_mid_pass();
        int n;
        bit ok;
        int e;
        do_clear();
        start_pass();
        n = 0;
        while (wr_cnt < 83 && n < 2000) begin @(negedge clk); n++; end
        total++;
        if (out_wr_en !== 1'b1 || tile_row !== 8'd1 || tile_col !== 8'd1) begin
            bad++;
            $display("FAIL store_tile5: wr_en=%b row=%0d col=%0d want 1 1 1",
                     out_wr_en, tile_row, tile_col);
        end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, error, fmap_rd_en, conv_start, conv_rst_n, out_wr_en,
             fmap_addr, out_addr, out_wdata, tile_row, tile_col} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: busy=%b done=%b rst_n=%b wr_en=%b oaddr=%0d row=%0d col=%0d want all 0",
                     busy, done, conv_rst_n, out_wr_en, out_addr, tile_row, tile_col);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_idle: pulses=%0d busy=%b want 0 0", done_cnt, busy);
        end
        do_clear();
        start_pass();
        total++;
        if (fmap_rd_en !== 1'b1 || fmap_addr !== 10'd0 || tile_row !== 8'd0 || tile_col !== 8'd0) begin
            bad++;
            $display("FAIL restart_origin: rd_en=%b addr=%0d row=%0d col=%0d want 1 0 0 0",
                     fmap_rd_en, fmap_addr, tile_row, tile_col);
        end
        wait_done(3000, n, ok);
        e = count_out_errors();
        total++;
        if (!ok || n != PASS_CYC || e != 0) begin
            bad++;
            $display("FAIL restart_pass: done=%b cycles=%0d wrong_words=%0d want 1 %0d 0",
                     ok, n, e, PASS_CYC);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        spur_done = 1'b0;
        eng_off   = 1'b0;
        clr       = 1'b0;
        for (int a = 0; a < 1024; a++) fmap_mem[a] = 8'(a);
        for (int u = 0; u < 3; u++)
            for (int v = 0; v < 3; v++)
                kern[u][v] = int'($urandom_range(15)) - 8;

        test_reset();
        test_full_pass();
        test_start_in_wait();
        test_timeout();
        test_reset_mid_pass();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
